alu_chain_seq: RTL and testbench

//  Sequences the shared 8-bit ALU to run multi-byte (NBYTES*8-bit) arithmetic, shift and logic commands.

---
 rtl/alu_chain_pkg.sv | 48 ++++
 rtl/alu_chain_decode.sv | 63 ++++++
 rtl/alu_chain_seq.sv | 240 ++++++++++++++++++++++++
 tb/tb_alu_chain_seq.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_chain_pkg.sv
// alu_chain_pkg
//   Shared definitions for the multi-byte ALU sequencer:
//   - cmd_e   : external command codes carried on cmd_op
//   - state_e : sequencer FSM states
//   - ALU_*   : operation codes driven onto the shared 8-bit ALU
//   - is_shift / is_arith : small classifiers on ALU op codes
package alu_chain_pkg;

    typedef enum logic [3:0] {
        CMD_ADD = 4'd0,
        CMD_SUB = 4'd1,
        CMD_ASL = 4'd2,
        CMD_ROL = 4'd3,
        CMD_LSR = 4'd4,
        CMD_ROR = 4'd5,
        CMD_AND = 4'd6,
        CMD_ORA = 4'd7,
        CMD_EOR = 4'd8
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // ALU op codes; ASL and ROL share SHL, LSR and ROR share SHR.
    // They differ only in the carry fed into the first byte.
    localparam logic [3:0] ALU_ADD = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0111;
    localparam logic [3:0] ALU_SHL = 4'b1011;
    localparam logic [3:0] ALU_ORA = 4'b1100;
    localparam logic [3:0] ALU_AND = 4'b1101;
    localparam logic [3:0] ALU_EOR = 4'b1110;
    localparam logic [3:0] ALU_SHR = 4'b1111;

    // Shifts take no B operand.
    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SHL) || (op == ALU_SHR);
    endfunction

    // Only add/subtract produce a meaningful overflow flag.
    function automatic logic is_arith(input logic [3:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_chain_decode.sv
// alu_chain_decode
//   Combinational translation of a command code into ALU controls.
//   Ports:
//     cmd_op     in  4  command code (alu_chain_pkg::cmd_e)
//     alu_op     out 4  op code for the 8-bit ALU
//     right      out 1  ALU shift direction (1 = right)
//     msb_first  out 1  process bytes from most significant downwards
//     use_ci     out 1  command carry-in seeds the first byte
//     use_bcd    out 1  command BCD bit is forwarded to the ALU
//     err        out 1  code is not a defined command
module alu_chain_decode
    import alu_chain_pkg::*;
(
    input  logic [3:0] cmd_op,
    output logic [3:0] alu_op,
    output logic       right,
    output logic       msb_first,
    output logic       use_ci,
    output logic       use_bcd,
    output logic       err
);

    always_comb begin
        alu_op    = ALU_ADD;
        right     = 1'b0;
        msb_first = 1'b0;
        use_ci    = 1'b0;
        use_bcd   = 1'b0;
        err       = 1'b0;
        case (cmd_op)
            CMD_ADD: begin
                use_ci  = 1'b1;
                use_bcd = 1'b1;
            end
            CMD_SUB: begin
                alu_op  = ALU_SUB;
                use_ci  = 1'b1;
                use_bcd = 1'b1;
            end
            CMD_ASL: alu_op = ALU_SHL;
            CMD_ROL: begin
                alu_op = ALU_SHL;
                use_ci = 1'b1;
            end
            CMD_LSR: begin
                alu_op    = ALU_SHR;
                right     = 1'b1;
                msb_first = 1'b1;
            end
            CMD_ROR: begin
                alu_op    = ALU_SHR;
                right     = 1'b1;
                msb_first = 1'b1;
                use_ci    = 1'b1;
            end
            CMD_AND: alu_op = ALU_AND;
            CMD_ORA: alu_op = ALU_ORA;
            CMD_EOR: alu_op = ALU_EOR;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_chain_seq.sv
// alu_chain_seq
//   Runs NBYTES*8-bit commands through a shared 8-bit ALU one byte per
//   granted cycle, chaining carry between bytes and gathering the result
//   bytes and flags.
//   Ports:
//     clk, reset                  clock; asynchronous active-high reset
//     cmd_valid/cmd_ready         command handshake (ready only in IDLE)
//     cmd_op, cmd_a, cmd_b        command code and W-bit operands
//     cmd_ci, cmd_bcd             start carry and BCD request
//     res_valid/res_ready         result handshake, result held until taken
//     res_data, res_c/v/n/z/err   W-bit result and flags
//     alu_req/alu_gnt             ALU ownership request / grant
//     alu_op, alu_right, alu_ai, alu_bi, alu_ci, alu_bcd, alu_rdy
//                                 controls and operands driven to the ALU
//     alu_out, alu_co/v/z/n       registered ALU result and flags
module alu_chain_seq
    import alu_chain_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [3:0]          cmd_op,
    input  logic [NBYTES*8-1:0] cmd_a,
    input  logic [NBYTES*8-1:0] cmd_b,
    input  logic                cmd_ci,
    input  logic                cmd_bcd,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [NBYTES*8-1:0] res_data,
    output logic                res_c,
    output logic                res_v,
    output logic                res_n,
    output logic                res_z,
    output logic                res_err,
    output logic                alu_req,
    input  logic                alu_gnt,
    output logic [3:0]          alu_op,
    output logic                alu_right,
    output logic [7:0]          alu_ai,
    output logic [7:0]          alu_bi,
    output logic                alu_ci,
    output logic                alu_bcd,
    output logic                alu_rdy,
    input  logic [7:0]          alu_out,
    input  logic                alu_co,
    input  logic                alu_v,
    input  logic                alu_z,
    input  logic                alu_n
);

    localparam int W    = NBYTES * 8;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    // Decoded command
    logic [3:0] dec_alu_op;
    logic       dec_right;
    logic       dec_msb_first;
    logic       dec_use_ci;
    logic       dec_use_bcd;
    logic       dec_err;

    alu_chain_decode u_decode (
        .cmd_op    (cmd_op),
        .alu_op    (dec_alu_op),
        .right     (dec_right),
        .msb_first (dec_msb_first),
        .use_ci    (dec_use_ci),
        .use_bcd   (dec_use_bcd),
        .err       (dec_err)
    );

    // Latched command
    state_e          state_reg;
    logic [IDXW-1:0] idx_reg;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [3:0]      op_reg;
    logic            right_reg;
    logic            msb_first_reg;
    logic            ci_start_reg;
    logic            bcd_reg;
    logic            err_reg;

    // Result gathering
    logic [7:0]      byte_reg [NBYTES];
    logic            z_acc_reg;
    logic            c_reg;
    logic            v_reg;
    logic            n_reg;

    // Registered result outputs
    logic            res_valid_reg;
    logic [W-1:0]    res_data_reg;
    logic            res_c_reg;
    logic            res_v_reg;
    logic            res_n_reg;
    logic            res_z_reg;
    logic            res_err_reg;

    // Byte views of operands and the gathered result
    logic [7:0]      a_bytes [NBYTES];
    logic [7:0]      b_bytes [NBYTES];
    logic [W-1:0]    gathered;

    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
        assign a_bytes[gi]          = a_reg[gi*8 +: 8];
        assign b_bytes[gi]          = b_reg[gi*8 +: 8];
        assign gathered[gi*8 +: 8]  = byte_reg[gi];
    end

    // idx counts processing steps; msb_first maps step k onto byte NBYTES-1-k.
    logic [IDXW-1:0] issue_pos;
    logic [IDXW-1:0] cap_step;
    logic [IDXW-1:0] cap_pos;
    logic            advance;
    logic            cap_en;

    assign issue_pos = msb_first_reg ? (LAST_IDX - idx_reg) : idx_reg;
    // The ALU result now on alu_out belongs to the step issued one grant ago.
    assign cap_step  = (state_reg == ST_DRAIN) ? LAST_IDX : (idx_reg - 1'b1);
    assign cap_pos   = msb_first_reg ? (LAST_IDX - cap_step) : cap_step;
    assign advance   = alu_gnt && alu_req;
    assign cap_en    = advance && ((state_reg == ST_DRAIN) || (idx_reg != '0));

    assign cmd_ready = (state_reg == ST_IDLE);
    assign alu_req   = (state_reg == ST_ISSUE) || (state_reg == ST_DRAIN);
    assign alu_rdy   = alu_gnt && (state_reg == ST_ISSUE);
    assign alu_op    = op_reg;
    assign alu_right = right_reg;
    assign alu_ai    = a_bytes[issue_pos];
    assign alu_bi    = b_bytes[issue_pos];
    // Later bytes chain the carry the ALU produced for the previous byte.
    assign alu_ci    = (idx_reg == '0) ? ci_start_reg : alu_co;
    assign alu_bcd   = bcd_reg;

    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign res_c     = res_c_reg;
    assign res_v     = res_v_reg;
    assign res_n     = res_n_reg;
    assign res_z     = res_z_reg;
    assign res_err   = res_err_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= '0;
            right_reg     <= 1'b0;
            msb_first_reg <= 1'b0;
            ci_start_reg  <= 1'b0;
            bcd_reg       <= 1'b0;
            err_reg       <= 1'b0;
            for (int i = 0; i < NBYTES; i++) begin
                byte_reg[i] <= '0;
            end
            z_acc_reg     <= 1'b0;
            c_reg         <= 1'b0;
            v_reg         <= 1'b0;
            n_reg         <= 1'b0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_c_reg     <= 1'b0;
            res_v_reg     <= 1'b0;
            res_n_reg     <= 1'b0;
            res_z_reg     <= 1'b0;
            res_err_reg   <= 1'b0;
        end else begin
            if (cap_en) begin
                byte_reg[cap_pos] <= alu_out;
                z_acc_reg         <= z_acc_reg & alu_z;
                // Sign of the whole result is the sign of its top byte.
                if (cap_pos == LAST_IDX) begin
                    n_reg <= alu_n;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        a_reg         <= cmd_a;
                        b_reg         <= is_shift(dec_alu_op) ? '0 : cmd_b;
                        op_reg        <= dec_alu_op;
                        right_reg     <= dec_right;
                        msb_first_reg <= dec_msb_first;
                        ci_start_reg  <= dec_use_ci & cmd_ci;
                        bcd_reg       <= dec_use_bcd & cmd_bcd;
                        err_reg       <= dec_err;
                        idx_reg       <= '0;
                        z_acc_reg     <= 1'b1;
                        c_reg         <= 1'b0;
                        v_reg         <= 1'b0;
                        n_reg         <= 1'b0;
                        state_reg     <= dec_err ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (alu_gnt) begin
                        if (idx_reg == LAST_IDX) begin
                            state_reg <= ST_DRAIN;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (alu_gnt) begin
                        c_reg     <= alu_co;
                        v_reg     <= is_arith(op_reg) & alu_v;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // First DONE cycle publishes the result; afterwards it is
                    // held untouched until the consumer takes it.
                    if (!res_valid_reg) begin
                        res_valid_reg <= 1'b1;
                        res_data_reg  <= err_reg ? '0 : gathered;
                        res_c_reg     <= ~err_reg & c_reg;
                        res_v_reg     <= ~err_reg & v_reg;
                        res_n_reg     <= ~err_reg & n_reg;
                        res_z_reg     <= ~err_reg & z_acc_reg;
                        res_err_reg   <= err_reg;
                    end else if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_chain_seq.sv
module tb_alu_chain_seq;

    localparam int NB = 4;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        cmd_ci;
    logic        cmd_bcd;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_c, res_v, res_n, res_z, res_err;
    logic        alu_req;
    logic        alu_gnt;
    logic [3:0]  alu_op;
    logic        alu_right;
    logic [7:0]  alu_ai, alu_bi;
    logic        alu_ci, alu_bcd, alu_rdy;
    logic [7:0]  alu_out;
    logic        alu_co, alu_v, alu_z, alu_n;

    int total = 0;
    int bad   = 0;

    logic gnt_dir;
    logic rand_gnt;
    logic gnt_rand;
    assign alu_gnt = rand_gnt ? gnt_rand : gnt_dir;

    alu_chain_seq #(.NBYTES(NB)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_ci(cmd_ci), .cmd_bcd(cmd_bcd),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_c(res_c), .res_v(res_v), .res_n(res_n), .res_z(res_z), .res_err(res_err),
        .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_op(alu_op), .alu_right(alu_right),
        .alu_ai(alu_ai), .alu_bi(alu_bi), .alu_ci(alu_ci), .alu_bcd(alu_bcd),
        .alu_rdy(alu_rdy), .alu_out(alu_out), .alu_co(alu_co), .alu_v(alu_v),
        .alu_z(alu_z), .alu_n(alu_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- 8-bit ALU (external to the DUT) ----------------
    function automatic logic [9:0] alu_byte(input logic [3:0] op, input logic right,
                                            input logic [7:0] ai, input logic [7:0] bi,
                                            input logic ci);
        logic [8:0] s;
        logic [7:0] o;
        logic       co;
        logic       v;
        o = 8'h00; co = 1'b0; v = 1'b0;
        case (op)
            4'b0011: begin
                s = {1'b0, ai} + {1'b0, bi} + 9'(ci);
                o = s[7:0]; co = s[8];
                v = (ai[7] == bi[7]) && (o[7] != ai[7]);
            end
            4'b0111: begin
                s = {1'b0, ai} + {1'b0, ~bi} + 9'(ci);
                o = s[7:0]; co = s[8];
                v = (ai[7] != bi[7]) && (o[7] != ai[7]);
            end
            4'b1011, 4'b1111: begin
                if (right) begin o = {ci, ai[7:1]}; co = ai[0]; end
                else       begin o = {ai[6:0], ci}; co = ai[7]; end
            end
            4'b1101: o = ai & bi;
            4'b1100: o = ai | bi;
            4'b1110: o = ai ^ bi;
            default: o = 8'h00;
        endcase
        return {co, v, o};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_out <= 8'h00; alu_co <= 1'b0; alu_v <= 1'b0; alu_z <= 1'b0; alu_n <= 1'b0;
        end else if (alu_rdy) begin
            logic [9:0] r;
            r = alu_byte(alu_op, alu_right, alu_ai, alu_bi, alu_ci);
            alu_out <= r[7:0];
            alu_co  <= r[9];
            alu_v   <= r[8];
            alu_z   <= (r[7:0] == 8'h00);
            alu_n   <= r[7];
            // The bench never requests BCD, and shifts must not present B.
            chk("alu_bcd", {31'd0, alu_bcd}, 32'd0);
            if (alu_op == 4'b1011 || alu_op == 4'b1111) chk("shift_bi", {24'd0, alu_bi}, 32'd0);
        end
    end

    always @(negedge clk) gnt_rand = ($urandom_range(0, 3) != 0);

    // ---------------- Reference model (whole-word arithmetic) ----------------
    // Returns {err, c, v, n, z, data}
    function automatic logic [36:0] ref_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic ci);
        logic [32:0] s;
        logic [31:0] d;
        logic        c, v, err;
        d = 32'd0; c = 1'b0; v = 1'b0; err = 1'b0;
        case (op)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b} + 33'(ci);
                d = s[31:0]; c = s[32];
                v = (a[31] == b[31]) && (d[31] != a[31]);
            end
            4'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'(ci);
                d = s[31:0]; c = s[32];
                v = (a[31] != b[31]) && (d[31] != a[31]);
            end
            4'd2: begin d = a << 1;          c = a[31]; end
            4'd3: begin d = {a[30:0], ci};   c = a[31]; end
            4'd4: begin d = a >> 1;          c = a[0];  end
            4'd5: begin d = {ci, a[31:1]};   c = a[0];  end
            4'd6: d = a & b;
            4'd7: d = a | b;
            4'd8: d = a ^ b;
            default: err = 1'b1;
        endcase
        return {err, c, v, d[31], (!err) && (d == 32'd0), d};
    endfunction

    // ---------------- Stimulus helpers ----------------
    task automatic start_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic ci, input logic bcd);
        @(negedge clk);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_ci = ci; cmd_bcd = bcd; cmd_valid = 1'b1;
        chk("cmd_ready_before_accept", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, inout int cyc);
        while (!res_valid && cyc < 80) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_valid_seen"}, {31'd0, res_valid}, 32'd1);
    endtask

    task automatic check_res(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic ci);
        logic [36:0] e;
        e = ref_model(op, a, b, ci);
        chk({tag, "_data"}, res_data, e[31:0]);
        chk({tag, "_z"}, {31'd0, res_z}, {31'd0, e[32]});
        chk({tag, "_n"}, {31'd0, res_n}, {31'd0, e[33]});
        chk({tag, "_v"}, {31'd0, res_v}, {31'd0, e[34]});
        chk({tag, "_c"}, {31'd0, res_c}, {31'd0, e[35]});
        chk({tag, "_err"}, {31'd0, res_err}, {31'd0, e[36]});
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, res_valid}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic run_cmd(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic ci, input logic bcd,
                           input int exp_lat);
        int cyc;
        cyc = 0;
        start_cmd(op, a, b, ci, bcd);
        wait_valid(tag, cyc);
        if (exp_lat >= 0) chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check_res(tag, op, a, b, ci);
        $display("txn %s op=%0d a=%08h b=%08h ci=%0d -> data=%08h c=%0d v=%0d n=%0d z=%0d err=%0d lat=%0d",
                 tag, op, a, b, ci, res_data, res_c, res_v, res_n, res_z, res_err, cyc);
        consume(tag);
    endtask

    // ---------------- Directed and random sequence ----------------
    initial begin
        int          cyc;
        logic [31:0] held;
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        logic        rci, rbcd;

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = '0; cmd_b = '0;
        cmd_ci = 1'b0; cmd_bcd = 1'b0; res_ready = 1'b0; gnt_dir = 1'b1; rand_gnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_alu_req", {31'd0, alu_req}, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // 1: carry across bytes, latency NBYTES+2
        run_cmd("t1_add", 4'd0, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 6);
        // 2: borrow through all bytes; signed overflow
        run_cmd("t2_sub", 4'd1, 32'h00000000, 32'h00000001, 1'b1, 1'b0, 6);
        run_cmd("t2_addv", 4'd0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 6);
        // 3: shifts in both byte orders
        run_cmd("t3_ror", 4'd5, 32'h00000001, 32'h12345678, 1'b1, 1'b0, 6);
        run_cmd("t3_lsr", 4'd4, 32'h00000100, 32'hFFFFFFFF, 1'b1, 1'b0, 6);
        run_cmd("t3_rol", 4'd3, 32'h80000000, 32'h0, 1'b0, 1'b0, 6);
        run_cmd("t3_asl", 4'd2, 32'hC0000001, 32'h0, 1'b1, 1'b0, 6);

        // 4: grant withdrawn for 3 cycles after byte 1 is issued
        cyc = 0;
        start_cmd(4'd0, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; cyc++; end
        gnt_dir = 1'b0;
        repeat (3) begin
            #1;
            chk("t4_rdy_low", {31'd0, alu_rdy}, 32'd0);
            chk("t4_req_high", {31'd0, alu_req}, 32'd1);
            @(posedge clk); #1; cyc++;
        end
        gnt_dir = 1'b1;
        wait_valid("t4_stall", cyc);
        chk("t4_latency", 32'(cyc), 32'd9);
        check_res("t4_stall", 4'd0, 32'h0000FFFF, 32'h00000001, 1'b0);
        $display("txn t4_stall data=%08h lat=%0d", res_data, cyc);
        consume("t4_stall");

        // 5: result held while not consumed; new commands ignored
        cyc = 0;
        start_cmd(4'd6, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1, 1'b1);
        wait_valid("t5_and", cyc);
        check_res("t5_and", 4'd6, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1);
        held = res_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1; cmd_op = 4'd7; cmd_a = $urandom; cmd_b = 32'hFFFFFFFF;
            chk("t5_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
            chk("t5_hold_valid", {31'd0, res_valid}, 32'd1);
            chk("t5_hold_data", res_data, 32'd0);
            chk("t5_hold_z", {31'd0, res_z}, 32'd1);
        end
        cmd_valid = 1'b0;
        $display("txn t5_and data=%08h held=%08h", res_data, held);
        consume("t5_and");

        // 6: reset mid-ISSUE, then an undefined op, then a clean command
        run_cmd("t6_pre", 4'd0, 32'h12345678, 32'h11111111, 1'b0, 1'b0, 6);
        start_cmd(4'd1, 32'hAAAA5555, 32'h5555AAAA, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("t6_res_valid", {31'd0, res_valid}, 32'd0);
        chk("t6_alu_req", {31'd0, alu_req}, 32'd0);
        chk("t6_res_data", res_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_cmd("t6_undef", 4'hF, 32'hDEADBEEF, 32'h1, 1'b1, 1'b0, -1);
        run_cmd("t6_clean", 4'd0, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 6);

        // Random commands with a randomly stalling arbiter
        rand_gnt = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rop  = 4'($urandom_range(0, 9));
            if (i % 13 == 12) rop = 4'hF;
            ra   = $urandom;
            rb   = $urandom;
            rci  = 1'($urandom_range(0, 1));
            rbcd = (rop <= 4'd1) ? 1'b0 : 1'($urandom_range(0, 1));
            run_cmd($sformatf("rnd%0d", i), rop, ra, rb, rci, rbcd, -1);
        end
        rand_gnt = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
